seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment encoder. The block watches a multiplexed, active-low seven-segment display bus (digit enables plus segment lines) and reconstructs the hex value being shown, one nibble per digit. It accepts a pattern only after it has been stable for a set time, and it flags unknown glyphs. It sits on the display pins as a loopback/self-test monitor, or as the front end of a board that receives another board's display bus.

---
 rtl/seg7_scan_decoder.sv | 252 +++++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a multiplexed, active-low seven-segment display bus and rebuilds
// the hex value shown on each digit. A pattern is accepted only after it has
// been stable for STABLE_CYCLES consecutive registered samples. Unknown glyphs
// and illegal digit enables are flagged.
//
// Optional feature macro: SEG7_DEC_ALT7_EN
//   When defined, the glyph 0x07 (seven drawn without segment f) is also
//   decoded as nibble 7. When undefined, 0x07 is an unknown glyph.
//
// Parameters
//   DIGITS        number of multiplexed digits (1..8)
//   STABLE_CYCLES identical samples needed before a commit (>= 2)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   an_n        digit enables, active low, one low bit selects a digit
//   seg_n       segments, active low: bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a
//   value       decoded nibbles, digit d at [4d+3:4d]
//   dp          decimal point per digit (1 = lit)
//   digit_ok    1 = last commit for that digit was a known glyph
//   update      one-cycle pulse on each successful commit
//   err         one-cycle pulse on an unknown glyph or illegal an_n
//   frame_done  one-cycle pulse when every digit has been committed
//   frame_valid &digit_ok captured at the last frame_done
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [7:0]            seg_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  update,
    output logic                  err,
    output logic                  frame_done,
    output logic                  frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Registered copies of the display pins.
    logic [DIGITS-1:0] an_reg;
    logic [7:0]        seg_reg;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;

    logic [DIGITS-1:0] seen_reg, seen_next;
    logic [DIGITS-1:0] digit_ok_reg, digit_ok_next;
    logic [DIGITS-1:0] digit_hit;
    logic              update_reg, err_reg, frame_done_reg, frame_valid_reg;

    logic              samp_legal;
    logic              samp_multi_low;
    logic              prev_illegal;
    logic              samp_same;
    logic              commit;
    logic              illegal_err;
    logic              frame_complete;

    logic [6:0]        glyph;
    logic              glyph_known;
    logic [3:0]        glyph_nib;
    logic [IW-1:0]     digit_idx;

    // -------------------------------------------------------------------------
    // Input capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg  <= '1;
            seg_reg <= '1;
        end else begin
            an_reg  <= an_n;
            seg_reg <= seg_n;
        end
    end

    // -------------------------------------------------------------------------
    // Sample classification
    //
    // The FSM judges each sample on the same edge that loads it into
    // an_reg/seg_reg, so state_reg and count_reg always describe the run that
    // ends with the current contents of the input registers. count_reg is
    // therefore the number of identical registered samples, and a commit lands
    // on the edge that registers the STABLE_CYCLES-th one.
    // -------------------------------------------------------------------------
    always_comb begin
        samp_legal     = $onehot(~an_n);
        samp_multi_low = !samp_legal && !(&an_n);
        prev_illegal   = !$onehot(~an_reg) && !(&an_reg);
        samp_same      = (an_n == an_reg) && (seg_n == seg_reg);
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        commit      = 1'b0;
        illegal_err = 1'b0;

        if (state_reg != IDLE && samp_same) begin
            if (state_reg == TRACK) begin
                if (count_reg == CW'(STABLE_CYCLES - 1)) begin
                    count_next = CW'(STABLE_CYCLES);
                    commit     = 1'b1;
                    state_next = HOLD;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            // HOLD with an unchanged sample: nothing to do, never recommit.
        end else if (samp_legal) begin
            // New legal sample (from IDLE, or a change while tracking/holding).
            state_next = TRACK;
            count_next = CW'(1);
        end else begin
            // Dead time or multiple enables. Only the first illegal sample
            // of a stretch raises err, so a held illegal pattern pulses once.
            state_next  = IDLE;
            count_next  = '0;
            illegal_err = samp_multi_low && !prev_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Glyph decode and digit index. A commit only happens when the incoming
    // sample equals the registered one, so the registered copy is decoded.
    // -------------------------------------------------------------------------
    always_comb begin
        glyph       = ~seg_reg[6:0];
        glyph_known = 1'b1;
        glyph_nib   = 4'h0;
        case (glyph)
            7'h3F: glyph_nib = 4'h0;
            7'h06: glyph_nib = 4'h1;
            7'h5B: glyph_nib = 4'h2;
            7'h4F: glyph_nib = 4'h3;
            7'h66: glyph_nib = 4'h4;
            7'h6D: glyph_nib = 4'h5;
            7'h7D: glyph_nib = 4'h6;
            7'h27: glyph_nib = 4'h7;
            7'h7F: glyph_nib = 4'h8;
            7'h6F: glyph_nib = 4'h9;
            7'h77: glyph_nib = 4'hA;
            7'h7C: glyph_nib = 4'hB;
            7'h39: glyph_nib = 4'hC;
            7'h5E: glyph_nib = 4'hD;
            7'h79: glyph_nib = 4'hE;
            7'h71: glyph_nib = 4'hF;
`ifdef SEG7_DEC_ALT7_EN
            7'h07: glyph_nib = 4'h7;
`endif
            default: glyph_known = 1'b0;
        endcase
    end

    always_comb begin
        digit_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_reg[i]) begin
                digit_idx = IW'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-digit storage
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib_reg;
            logic       dp_bit_reg;

            assign digit_hit[gi]     = commit && (digit_idx == IW'(gi));
            assign digit_ok_next[gi] = digit_hit[gi] ? glyph_known : digit_ok_reg[gi];
            assign seen_next[gi]     = seen_reg[gi] | digit_hit[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    nib_reg    <= 4'h0;
                    dp_bit_reg <= 1'b0;
                end else if (digit_hit[gi] && glyph_known) begin
                    nib_reg    <= glyph_nib;
                    dp_bit_reg <= ~seg_reg[7];
                end
            end

            assign value[4*gi +: 4] = nib_reg;
            assign dp[gi]           = dp_bit_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pulses and frame tracking
    // -------------------------------------------------------------------------
    assign frame_complete = commit && (&seen_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_ok_reg    <= '0;
            seen_reg        <= '0;
            update_reg      <= 1'b0;
            err_reg         <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            digit_ok_reg   <= digit_ok_next;
            seen_reg       <= frame_complete ? '0 : seen_next;
            update_reg     <= commit && glyph_known;
            err_reg        <= illegal_err || (commit && !glyph_known);
            frame_done_reg <= frame_complete;
            if (frame_complete) begin
                frame_valid_reg <= &digit_ok_next;
            end
        end
    end

    assign digit_ok    = digit_ok_reg;
    assign update      = update_reg;
    assign err         = err_reg;
    assign frame_done  = frame_done_reg;
    assign frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed testbench for seg7_scan_decoder with DIGITS=4, STABLE_CYCLES=4.
// Each scenario task drives the display bus and compares outputs against
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_n;
    logic [7:0]  seg_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_ok;
    logic        update;
    logic        err;
    logic        frame_done;
    logic        frame_valid;

    int n_checks  = 0;
    int n_fail    = 0;
    int upd_cnt   = 0;
    int err_cnt   = 0;
    int fd_cnt    = 0;
    int first_upd = -1;

    seg7_scan_decoder #(
        .DIGITS        (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .value       (value),
        .dp          (dp),
        .digit_ok    (digit_ok),
        .update      (update),
        .err         (err),
        .frame_done  (frame_done),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        upd_cnt   = 0;
        err_cnt   = 0;
        fd_cnt    = 0;
        first_upd = -1;
    endtask

    // Drive one pattern for cyc rising edges, counting output pulses.
    // first_upd is the edge number (1 = capture edge) of the first update.
    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int cyc);
        @(negedge clk);
        an_n  = a;
        seg_n = s;
        for (int k = 1; k <= cyc; k++) begin
            @(posedge clk);
            #1;
            if (update === 1'b1) begin
                upd_cnt++;
                if (first_upd < 0) first_upd = k;
            end
            if (err === 1'b1) err_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (value !== 16'h0000) begin n_fail++; $display("FAIL reset_value: got %h expected %h", value, 16'h0000); end
        n_checks++;
        if (dp !== 4'h0) begin n_fail++; $display("FAIL reset_dp: got %b expected %b", dp, 4'h0); end
        n_checks++;
        if (digit_ok !== 4'h0) begin n_fail++; $display("FAIL reset_digit_ok: got %b expected %b", digit_ok, 4'h0); end
        n_checks++;
        if ({update, err, frame_done, frame_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected %b", {update, err, frame_done, frame_valid}, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_known_digit();
        clear_counts();
        drive(4'b1110, ~8'h4F, 8);
        drive(4'b1111, 8'hFF, 2);
        n_checks++;
        if (value[3:0] !== 4'h3) begin n_fail++; $display("FAIL known_value: got %h expected %h", value[3:0], 4'h3); end
        n_checks++;
        if (digit_ok[0] !== 1'b1) begin n_fail++; $display("FAIL known_ok: got %b expected %b", digit_ok[0], 1'b1); end
        n_checks++;
        if (upd_cnt != 1) begin n_fail++; $display("FAIL known_update_count: got %0d expected %0d", upd_cnt, 1); end
        n_checks++;
        if (first_upd != 4) begin n_fail++; $display("FAIL known_latency: got edge %0d expected edge %0d", first_upd, 4); end
        n_checks++;
        if (err_cnt != 0) begin n_fail++; $display("FAIL known_err: got %0d expected %0d", err_cnt, 0); end
        n_checks++;
        if (dp[0] !== 1'b0) begin n_fail++; $display("FAIL known_dp: got %b expected %b", dp[0], 1'b0); end
        $display("test_known_digit: value=%h upd=%0d first_upd=%0d", value, upd_cnt, first_upd);
    endtask

    task automatic test_full_frame();
        logic [3:0] an_tab [4];
        logic [7:0] seg_tab [4];
        an_tab[0] = 4'b1110; seg_tab[0] = ~8'h06;
        an_tab[1] = 4'b1101; seg_tab[1] = ~8'h5B;
        an_tab[2] = 4'b1011; seg_tab[2] = ~8'h4F;
        an_tab[3] = 4'b0111; seg_tab[3] = ~8'hE6;   // glyph 4 with dp lit
        apply_reset();
        clear_counts();
        for (int d = 0; d < 4; d++) begin
            drive(an_tab[d], seg_tab[d], 6);
            drive(4'b1111, 8'hFF, 2);
        end
        n_checks++;
        if (value !== 16'h4321) begin n_fail++; $display("FAIL frame_value: got %h expected %h", value, 16'h4321); end
        n_checks++;
        if (fd_cnt != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d expected %0d", fd_cnt, 1); end
        n_checks++;
        if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid: got %b expected %b", frame_valid, 1'b1); end
        n_checks++;
        if (upd_cnt != 4) begin n_fail++; $display("FAIL frame_updates: got %0d expected %0d", upd_cnt, 4); end
        n_checks++;
        if (err_cnt != 0) begin n_fail++; $display("FAIL frame_err: got %0d expected %0d", err_cnt, 0); end
        n_checks++;
        if (dp !== 4'b1000) begin n_fail++; $display("FAIL frame_dp: got %b expected %b", dp, 4'b1000); end
        n_checks++;
        if (digit_ok !== 4'b1111) begin n_fail++; $display("FAIL frame_ok: got %b expected %b", digit_ok, 4'b1111); end
        $display("test_full_frame: value=%h dp=%b frames=%0d valid=%b", value, dp, fd_cnt, frame_valid);
    endtask

    task automatic test_unknown_glyph();
        clear_counts();
        drive(4'b1011, ~8'h49, 6);
        drive(4'b1111, 8'hFF, 2);
        n_checks++;
        if (err_cnt != 1) begin n_fail++; $display("FAIL unknown_err_count: got %0d expected %0d", err_cnt, 1); end
        n_checks++;
        if (upd_cnt != 0) begin n_fail++; $display("FAIL unknown_update: got %0d expected %0d", upd_cnt, 0); end
        n_checks++;
        if (digit_ok !== 4'b1011) begin n_fail++; $display("FAIL unknown_ok: got %b expected %b", digit_ok, 4'b1011); end
        n_checks++;
        if (value !== 16'h4321) begin n_fail++; $display("FAIL unknown_value: got %h expected %h", value, 16'h4321); end
        // Complete the next frame with good glyphs on the other digits.
        clear_counts();
        drive(4'b1110, ~8'h6D, 6);
        drive(4'b1111, 8'hFF, 2);
        drive(4'b1101, ~8'h7D, 6);
        drive(4'b1111, 8'hFF, 2);
        drive(4'b0111, ~8'h27, 6);
        drive(4'b1111, 8'hFF, 2);
        n_checks++;
        if (fd_cnt != 1) begin n_fail++; $display("FAIL unknown_frame_done: got %0d expected %0d", fd_cnt, 1); end
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL unknown_frame_valid: got %b expected %b", frame_valid, 1'b0); end
        n_checks++;
        if (value !== 16'h7365) begin n_fail++; $display("FAIL unknown_frame_value: got %h expected %h", value, 16'h7365); end
        n_checks++;
        if (dp !== 4'b0000) begin n_fail++; $display("FAIL unknown_frame_dp: got %b expected %b", dp, 4'b0000); end
        $display("test_unknown_glyph: value=%h ok=%b valid=%b", value, digit_ok, frame_valid);
    endtask

    task automatic test_glitch();
        clear_counts();
        drive(4'b1101, ~8'h06, 3);
        drive(4'b1110, ~8'h3F, 3);
        drive(4'b1111, 8'hFF, 2);
        n_checks++;
        if (upd_cnt != 0) begin n_fail++; $display("FAIL glitch_update: got %0d expected %0d", upd_cnt, 0); end
        n_checks++;
        if (err_cnt != 0) begin n_fail++; $display("FAIL glitch_err: got %0d expected %0d", err_cnt, 0); end
        n_checks++;
        if (value !== 16'h7365) begin n_fail++; $display("FAIL glitch_value: got %h expected %h", value, 16'h7365); end
        // Exactly STABLE_CYCLES samples is enough to commit.
        clear_counts();
        drive(4'b1110, ~8'h3F, 4);
        drive(4'b1111, 8'hFF, 2);
        n_checks++;
        if (upd_cnt != 1) begin n_fail++; $display("FAIL boundary_update: got %0d expected %0d", upd_cnt, 1); end
        n_checks++;
        if (first_upd != 4) begin n_fail++; $display("FAIL boundary_latency: got edge %0d expected edge %0d", first_upd, 4); end
        n_checks++;
        if (value !== 16'h7360) begin n_fail++; $display("FAIL boundary_value: got %h expected %h", value, 16'h7360); end
        $display("test_glitch: value=%h upd=%0d", value, upd_cnt);
    endtask

    task automatic test_illegal_and_reset();
        clear_counts();
        drive(4'b1100, ~8'h3F, 10);
        drive(4'b1111, 8'hFF, 2);
        n_checks++;
        if (err_cnt != 1) begin n_fail++; $display("FAIL illegal_err_count: got %0d expected %0d", err_cnt, 1); end
        n_checks++;
        if (upd_cnt != 0) begin n_fail++; $display("FAIL illegal_update: got %0d expected %0d", upd_cnt, 0); end
        n_checks++;
        if (value !== 16'h7360) begin n_fail++; $display("FAIL illegal_value: got %h expected %h", value, 16'h7360); end
        // Reset in the middle of a run.
        clear_counts();
        drive(4'b1110, ~8'h06, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (value !== 16'h0000) begin n_fail++; $display("FAIL midreset_value: got %h expected %h", value, 16'h0000); end
        n_checks++;
        if (digit_ok !== 4'h0) begin n_fail++; $display("FAIL midreset_ok: got %b expected %b", digit_ok, 4'h0); end
        n_checks++;
        if ({update, err, frame_done, frame_valid, dp} !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b expected %b", {update, err, frame_done, frame_valid, dp}, 8'h00);
        end
        // Release with the same pattern still applied: three more samples
        // must not complete the discarded run.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (update === 1'b1) upd_cnt++;
            if (err === 1'b1) err_cnt++;
        end
        drive(4'b1111, 8'hFF, 2);
        n_checks++;
        if (upd_cnt != 0) begin n_fail++; $display("FAIL midreset_discard: got %0d updates expected %0d", upd_cnt, 0); end
        $display("test_illegal_and_reset: err=%0d upd=%0d", err_cnt, upd_cnt);
    endtask

    task automatic test_alt7();
        clear_counts();
        drive(4'b1101, ~8'h07, 6);
        drive(4'b1111, 8'hFF, 2);
`ifdef SEG7_DEC_ALT7_EN
        n_checks++;
        if (value[7:4] !== 4'h7) begin n_fail++; $display("FAIL alt7_value: got %h expected %h", value[7:4], 4'h7); end
        n_checks++;
        if (upd_cnt != 1) begin n_fail++; $display("FAIL alt7_update: got %0d expected %0d", upd_cnt, 1); end
        n_checks++;
        if (digit_ok[1] !== 1'b1) begin n_fail++; $display("FAIL alt7_ok: got %b expected %b", digit_ok[1], 1'b1); end
`else
        n_checks++;
        if (err_cnt != 1) begin n_fail++; $display("FAIL alt7_err: got %0d expected %0d", err_cnt, 1); end
        n_checks++;
        if (digit_ok[1] !== 1'b0) begin n_fail++; $display("FAIL alt7_ok: got %b expected %b", digit_ok[1], 1'b0); end
        n_checks++;
        if (value[7:4] !== 4'h0) begin n_fail++; $display("FAIL alt7_value: got %h expected %h", value[7:4], 4'h0); end
        n_checks++;
        if (upd_cnt != 0) begin n_fail++; $display("FAIL alt7_update: got %0d expected %0d", upd_cnt, 0); end
`endif
        $display("test_alt7: value=%h ok=%b upd=%0d err=%0d", value, digit_ok, upd_cnt, err_cnt);
    endtask

    initial begin
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 8'hFF;
        test_reset();
        test_known_digit();
        test_full_frame();
        test_unknown_glyph();
        test_glitch();
        test_illegal_and_reset();
        test_alt7();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
